stack_ram: RTL and testbench
============================

Name: stack_ram

Overview:
- Storage-side responder for the processor stack. Accepts push/pop/load requests carrying the 2-bit stack op code and the 8-bit address produced by the stack pointer block, and stores or returns 8-bit data.
- Address window is BOTTOM..TOP (default 0xB0..0xFF, 80 entries).
- Enforces the window bounds, tracks occupancy, reports overflow and underflow.
- Gives pop data one cycle after acceptance, with a valid/ready handshake.

Parameters:
- TOP, 8'hFF, highest stack address; empty-stack pointer value.
- BOTTOM, 8'hB0, lowest writable stack address.
- DEPTH, TOP-BOTTOM+1 (80), number of storage entries (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- rw  in  2  op code: 00 nop, 01 push, 10 pop, 11 load pointer.
- addr  in  8  stack address. For push it is the pointer value; for pop it is pointer+1.
- wdata  in  8  push data; on load it carries the new pointer value (r0).
- rdata  out  8  pop data.
- rdata_valid  out  1  one-cycle pulse; rdata is valid.
- occupancy  out  7  entries currently held (0..DEPTH).
- overflow  out  1  sticky: push outside window attempted.
- underflow  out  1  sticky: pop outside window attempted.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, req_ready=1, rdata=0, rdata_valid=0, occupancy=0, overflow=0, underflow=0. Storage contents are undefined and are not cleared.
- Accept = req_valid & req_ready. No request is accepted while req_ready=0; requester holds its inputs stable.
- FSM states:
  - IDLE: req_ready=1.
  - RD: req_ready=0; the storage read is registered this cycle.
  - IDLE→RD on accepted pop. RD→IDLE unconditionally after 1 cycle.
- nop (00): acknowledged in the accept cycle; no state change.
- push (01): on the accept edge:
  - If BOTTOM<=addr<=TOP: mem[addr-BOTTOM]<=wdata; occupancy increments, saturating at DEPTH.
  - Otherwise: no write; overflow<=1.
  - Zero-latency; req_ready stays 1, so back-to-back pushes run one per cycle.
- pop (10):
  - Accept edge latches the index and moves to RD.
  - End of RD cycle: rdata<=mem[index], rdata_valid=1 for exactly one cycle (the cycle after RD), occupancy decrements, saturating at 0.
  - If addr is outside BOTTOM..TOP (e.g. 0x00 from an empty pointer wrapping): rdata<=0, underflow<=1, occupancy unchanged; rdata_valid still pulses.
  - Sustained pop throughput is one per 2 cycles.
- load (11):
  - If BOTTOM-1<=wdata<=TOP: occupancy<=TOP-wdata.
  - Otherwise: occupancy<=0 and overflow<=1.
  - overflow/underflow are otherwise unaffected by load.
- Sticky flags clear only on reset.
- Push then pop of the same address on consecutive accepts returns the pushed data; the write lands before the read is registered, so no hazard.
- Reset asserted mid-pop (in RD): rdata_valid is never produced; all outputs take reset values immediately.
- occupancy arithmetic is 7-bit unsigned and never wraps.

Optional Feature:
- Macro: STACK_PARITY_EN.
- Defined:
  - Each entry stores a 9th even-parity bit computed from wdata on push.
  - On pop the parity is checked; on mismatch, output parity_err (1 bit, sticky, reset 0) sets in the same cycle rdata_valid pulses.
  - rdata is still delivered.
- Undefined: no parity storage, no parity_err port, 8-bit entries.

Test Plan:
- Reset, then push 0xA5 at addr 0xFF, then pop at addr 0xFF → rdata_valid one cycle after pop's RD cycle with rdata=0xA5; occupancy 0→1→0; req_ready low only during RD.
- 80 pushes at addr 0xFF down to 0xB0 (data = addr), then push at 0xAF → occupancy=80, overflow=1, no write; then pop at 0xB0 → rdata=0xB0.
- Pop at addr 0x00 from reset state → rdata=0x00, rdata_valid pulse, underflow=1, occupancy stays 0.
- Load with wdata=0xF0 → occupancy=15; load with wdata=0x10 → occupancy=0, overflow=1.
- Pop accepted, rst_n driven low during RD → rdata_valid never asserts; all outputs at reset values before the next rising edge.
- STACK_PARITY_EN: push 0x3C, force stored parity bit flipped, pop → rdata=0x3C, parity_err=1 and remains 1 until reset.

Source files
------------

// File: rtl/stack_ram.sv
// Storage-side responder for the processor stack: push/pop/load with window bounds,
// occupancy tracking and sticky overflow/underflow. Define STACK_PARITY_EN for per-entry parity.
module stack_ram #(
    parameter logic [7:0] TOP    = 8'hFF,
    parameter logic [7:0] BOTTOM = 8'hB0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic [6:0] occupancy,
    output logic       overflow,
    output logic       underflow
`ifdef STACK_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DEPTH = int'(TOP) - int'(BOTTOM) + 1;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);
    localparam logic [7:0] DEPTH_8 = 8'(DEPTH);
`ifdef STACK_PARITY_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {ST_IDLE, ST_RD} state_t;
    state_t state_q, state_d;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // while req_ready is low the requester holds rw/addr/wdata stable.
    logic acc;
    assign acc = req_valid & req_ready;

    // Window tests use wrapped offsets so a single unsigned compare covers both bounds.
    logic [7:0]    off_a, off_l;
    logic          in_win, load_ok;
    logic [IW-1:0] idx, rd_idx;
    logic [6:0]    occ_load;
    logic          rd_bad;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry_w, rd_entry;

    assign off_a    = addr - BOTTOM;
    assign in_win   = off_a < DEPTH_8;
    assign idx      = IW'(addr - BOTTOM);
    assign off_l    = wdata - (BOTTOM - 8'd1);
    assign load_ok  = off_l <= DEPTH_8;
    assign occ_load = 7'(TOP - wdata);
    assign rd_entry = mem[rd_idx];
`ifdef STACK_PARITY_EN
    assign entry_w  = {^wdata, wdata};
`else
    assign entry_w  = wdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc && rw == OP_POP) state_d = ST_RD;
            ST_RD:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
    end

    // Storage is never reset; its contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (acc && rw == OP_PUSH && in_win) mem[idx] <= entry_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx      <= '0;
            rd_bad      <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            occupancy   <= 7'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
`ifdef STACK_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            if (acc) begin
                case (rw)
                    OP_PUSH: begin
                        if (in_win) begin
                            if (occupancy != DEPTH_C) occupancy <= occupancy + 7'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    OP_POP: begin
                        rd_idx <= idx;
                        rd_bad <= !in_win;
                    end
                    OP_LOAD: begin
                        if (load_ok) begin
                            occupancy <= occ_load;
                        end else begin
                            occupancy <= 7'd0;
                            overflow  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // End of the RD cycle: deliver the registered read.
            if (state_q == ST_RD) begin
                rdata_valid <= 1'b1;
                if (rd_bad) begin
                    rdata     <= 8'h00;
                    underflow <= 1'b1;
                end else begin
                    rdata <= rd_entry[7:0];
                    if (occupancy != 7'd0) occupancy <= occupancy - 7'd1;
`ifdef STACK_PARITY_EN
                    if (^rd_entry) parity_err <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_ram.sv
// Directed plus randomized bench for stack_ram against an address-indexed reference model.
// Define STACK_PARITY_EN to also exercise the parity check.
module tb_stack_ram;

    localparam int TOP    = 8'hFF;
    localparam int BOTTOM = 8'hB0;
    localparam int DEPTH  = TOP - BOTTOM + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [6:0] occupancy;
    logic       overflow;
    logic       underflow;
`ifdef STACK_PARITY_EN
    logic       parity_err;
`endif

    stack_ram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rw          (rw),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .occupancy   (occupancy),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef STACK_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: storage indexed by absolute address, plain counts and flags.
    logic [7:0] ref_mem [256];
    bit         ref_ok  [256];
    int         m_occ;
    bit         m_ovf;
    bit         m_unf;

    function automatic bit in_window(input int a);
        return (a >= BOTTOM) && (a <= TOP);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_occ"}, {1'b0, occupancy}, 8'(m_occ));
        chk({tag, "_ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
        chk({tag, "_unf"}, {7'd0, underflow}, {7'd0, m_unf});
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        rw        = 2'b00;
        addr      = 8'h00;
        wdata     = 8'h00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_occ = 0;
        m_ovf = 0;
        m_unf = 0;
        chk("rst_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rvalid", {7'd0, rdata_valid}, 8'd0);
`ifdef STACK_PARITY_EN
        chk("rst_perr", {7'd0, parity_err}, 8'd0);
`endif
        check_status("rst");
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        chk("push_ready_pre", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1; rw = 2'b01; addr = a; wdata = d;
        @(posedge clk);
        #1;
        idle_inputs();
        if (in_window(a)) begin
            ref_mem[a] = d;
            ref_ok[a]  = 1'b1;
            if (m_occ < DEPTH) m_occ++;
        end else begin
            m_ovf = 1'b1;
        end
        chk("push_ready_post", {7'd0, req_ready}, 8'd1);
        check_status("push");
    endtask

    task automatic pop(input logic [7:0] a);
        logic [7:0] exp_d;
        bit         chk_data;
        chk("pop_ready_pre", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1; rw = 2'b10; addr = a; wdata = $urandom_range(0, 255);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("pop_rd_ready", {7'd0, req_ready}, 8'd0);
        chk("pop_rd_rvalid", {7'd0, rdata_valid}, 8'd0);
        check_status("pop_rd");
        if (in_window(a)) begin
            exp_d    = ref_mem[a];
            chk_data = ref_ok[a];
            if (m_occ > 0) m_occ--;
        end else begin
            exp_d    = 8'h00;
            chk_data = 1'b1;
            m_unf    = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pop_rvalid", {7'd0, rdata_valid}, 8'd1);
        if (chk_data) chk("pop_rdata", rdata, exp_d);
        chk("pop_ready_post", {7'd0, req_ready}, 8'd1);
        check_status("pop");
        @(posedge clk);
        #1;
        chk("pop_rvalid_pulse", {7'd0, rdata_valid}, 8'd0);
    endtask

    task automatic load(input logic [7:0] w);
        chk("load_ready_pre", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1; rw = 2'b11; addr = $urandom_range(0, 255); wdata = w;
        @(posedge clk);
        #1;
        idle_inputs();
        if (int'(w) >= BOTTOM - 1 && int'(w) <= TOP) begin
            m_occ = TOP - int'(w);
        end else begin
            m_occ = 0;
            m_ovf = 1'b1;
        end
        check_status("load");
    endtask

    task automatic nop();
        req_valid = 1'b1; rw = 2'b00; addr = $urandom_range(0, 255); wdata = $urandom_range(0, 255);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("nop_ready", {7'd0, req_ready}, 8'd1);
        chk("nop_rvalid", {7'd0, rdata_valid}, 8'd0);
        check_status("nop");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
        rst_n = 1'b1;
        idle_inputs();
        #2;
        apply_reset();

        // Single push/pop round trip.
        push(8'hFF, 8'hA5);
        pop(8'hFF);

        // Fill the whole window, then overflow and saturation.
        apply_reset();
        for (int a = TOP; a >= BOTTOM; a--) push(8'(a), 8'(a));
        push(8'hAF, 8'h5A);
        chk("fill_no_write", ref_mem[8'hB0], 8'hB0);
        push(8'hFF, 8'hFF);
        pop(8'hB0);

        // Pop from an empty, wrapped pointer.
        apply_reset();
        pop(8'h00);

        // Pointer loads including both window edges.
        apply_reset();
        load(8'hAF);
        load(8'hFF);
        load(8'hF0);
        load(8'h10);

        // Push then pop of the same address on consecutive accepts.
        apply_reset();
        push(8'hC0, 8'h77);
        pop(8'hC0);

        // Randomized mix of all op codes.
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 4) push(8'($urandom_range(8'hA8, 8'hFF)), 8'($urandom_range(0, 255)));
            else if (sel <= 7) begin
                if ($urandom_range(0, 3) == 0) pop(8'($urandom_range(0, 8'hAF)));
                else pop(8'($urandom_range(BOTTOM, TOP)));
            end
            else if (sel == 8) load(8'($urandom_range(0, 255)));
            else nop();
        end

        // Reset asserted during the RD cycle of a pop.
        apply_reset();
        push(8'hD0, 8'h3F);
        push(8'hD1, 8'h81);
        pop(8'hD1);
        req_valid = 1'b1; rw = 2'b10; addr = 8'hD0;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("midpop_rd_ready", {7'd0, req_ready}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_occ = 0; m_ovf = 0; m_unf = 0;
        chk("midpop_ready", {7'd0, req_ready}, 8'd1);
        chk("midpop_rdata", rdata, 8'h00);
        chk("midpop_rvalid", {7'd0, rdata_valid}, 8'd0);
        check_status("midpop");
        @(posedge clk);
        #1;
        chk("midpop_rvalid_edge", {7'd0, rdata_valid}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midpop_rvalid_after", {7'd0, rdata_valid}, 8'd0);
        chk("midpop_ready_after", {7'd0, req_ready}, 8'd1);

`ifdef STACK_PARITY_EN
        // Corrupt one stored parity bit and pop it back.
        apply_reset();
        push(8'hFF, 8'h3C);
        dut.mem[7'h4F][8] = ~dut.mem[7'h4F][8];
        chk("par_before", {7'd0, parity_err}, 8'd0);
        pop(8'hFF);
        chk("par_err", {7'd0, parity_err}, 8'd1);
        push(8'hFE, 8'h01);
        pop(8'hFE);
        chk("par_sticky", {7'd0, parity_err}, 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
